// File: rtl/vme_bus_arb_if.sv
// Bundle for the two-requester VME arbiter: requester A/B ports and the single slave-side port.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface vme_bus_arb_if;
    logic [17:0] a_Addr;
    logic [17:0] b_Addr;
    logic [31:0] a_WrData;
    logic [31:0] b_WrData;
    logic        a_RdMem;
    logic        a_WrMem;
    logic        b_RdMem;
    logic        b_WrMem;
    logic [31:0] a_RdData;
    logic [31:0] b_RdData;
    logic        a_RdDone;
    logic        a_WrDone;
    logic        a_RdError;
    logic        a_WrError;
    logic        b_RdDone;
    logic        b_WrDone;
    logic        b_RdError;
    logic        b_WrError;
    logic [17:0] VMEAddr;
    logic [31:0] VMEWrData;
    logic        VMERdMem;
    logic        VMEWrMem;
    logic [31:0] VMERdData;
    logic        VMERdDone;
    logic        VMEWrDone;
    logic        VMERdError;
    logic        VMEWrError;
    logic [1:0]  gnt;

    modport master (
        input  a_Addr, b_Addr, a_WrData, b_WrData, a_RdMem, a_WrMem, b_RdMem, b_WrMem,
        output a_RdData, b_RdData, a_RdDone, a_WrDone, a_RdError, a_WrError,
        output b_RdDone, b_WrDone, b_RdError, b_WrError,
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem, gnt,
        input  VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
    );

    modport slave (
        output a_Addr, b_Addr, a_WrData, b_WrData, a_RdMem, a_WrMem, b_RdMem, b_WrMem,
        input  a_RdData, b_RdData, a_RdDone, a_WrDone, a_RdError, a_WrError,
        input  b_RdDone, b_WrDone, b_RdError, b_WrError,
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem, gnt,
        output VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
    );
endinterface

// File: rtl/vme_bus_arb.sv
// Round-robin arbiter giving requesters A and B one-at-a-time access to a single VME slave.
// Define VME_BUS_ARB_TIMEOUT_EN to add a slave-response timeout of TIMEOUT_CYCLES WAIT cycles.
module vme_bus_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic           Clk,
    input logic           rst_n,
    vme_bus_arb_if.master bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      r_state;
    logic [1:0]  r_gnt;
    logic        r_last_b;
    logic        r_op_wr;
    logic [17:0] r_vme_addr;
    logic [31:0] r_vme_wdata;
    logic        r_vme_rd;
    logic        r_vme_wr;
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;
    logic        r_a_rd_done, r_a_wr_done, r_a_rd_err, r_a_wr_err;
    logic        r_b_rd_done, r_b_wr_done, r_b_rd_err, r_b_wr_err;

    logic w_req_a, w_req_b, w_pick_b, w_pick_wr;
    logic w_rsp_done, w_rsp_err, w_rsp, w_tmo, w_fin, w_fin_err;

    assign w_req_a  = bus.a_RdMem | bus.a_WrMem;
    assign w_req_b  = bus.b_RdMem | bus.b_WrMem;
    // B wins only when A is idle or A was the last owner.
    assign w_pick_b  = w_req_b & (~w_req_a | ~r_last_b);
    assign w_pick_wr = w_pick_b ? bus.b_WrMem : bus.a_WrMem;

    assign w_rsp_done = r_op_wr ? bus.VMEWrDone  : bus.VMERdDone;
    assign w_rsp_err  = r_op_wr ? bus.VMEWrError : bus.VMERdError;
    assign w_rsp      = w_rsp_done | w_rsp_err;

`ifdef VME_BUS_ARB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StIssue) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StWait) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_tmo = (r_state == StWait) && (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo = 1'b0;
`endif

    // A slave response on the timeout cycle takes precedence over the timeout.
    assign w_fin     = w_rsp | w_tmo;
    assign w_fin_err = w_rsp ? w_rsp_err : 1'b1;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_gnt       <= 2'b00;
            r_last_b    <= 1'b1;
            r_op_wr     <= 1'b0;
            r_vme_addr  <= '0;
            r_vme_wdata <= '0;
            r_vme_rd    <= 1'b0;
            r_vme_wr    <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_a_rd_done <= 1'b0;
            r_a_wr_done <= 1'b0;
            r_a_rd_err  <= 1'b0;
            r_a_wr_err  <= 1'b0;
            r_b_rd_done <= 1'b0;
            r_b_wr_done <= 1'b0;
            r_b_rd_err  <= 1'b0;
            r_b_wr_err  <= 1'b0;
        end else begin
            r_vme_rd    <= 1'b0;
            r_vme_wr    <= 1'b0;
            r_a_rd_done <= 1'b0;
            r_a_wr_done <= 1'b0;
            r_a_rd_err  <= 1'b0;
            r_a_wr_err  <= 1'b0;
            r_b_rd_done <= 1'b0;
            r_b_wr_done <= 1'b0;
            r_b_rd_err  <= 1'b0;
            r_b_wr_err  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_req_a || w_req_b) begin
                        r_gnt       <= w_pick_b ? 2'b10 : 2'b01;
                        r_last_b    <= w_pick_b;
                        r_op_wr     <= w_pick_wr;
                        r_vme_addr  <= w_pick_b ? bus.b_Addr : bus.a_Addr;
                        r_vme_wdata <= w_pick_b ? bus.b_WrData : bus.a_WrData;
                        r_vme_rd    <= ~w_pick_wr;
                        r_vme_wr    <= w_pick_wr;
                        r_state     <= StIssue;
                    end
                end
                StIssue, StWait: begin
                    if (w_fin) begin
                        r_state     <= StResp;
                        r_a_rd_done <= r_gnt[0] & ~r_op_wr & ~w_fin_err;
                        r_a_rd_err  <= r_gnt[0] & ~r_op_wr &  w_fin_err;
                        r_a_wr_done <= r_gnt[0] &  r_op_wr & ~w_fin_err;
                        r_a_wr_err  <= r_gnt[0] &  r_op_wr &  w_fin_err;
                        r_b_rd_done <= r_gnt[1] & ~r_op_wr & ~w_fin_err;
                        r_b_rd_err  <= r_gnt[1] & ~r_op_wr &  w_fin_err;
                        r_b_wr_done <= r_gnt[1] &  r_op_wr & ~w_fin_err;
                        r_b_wr_err  <= r_gnt[1] &  r_op_wr &  w_fin_err;
                        if (w_rsp && !r_op_wr) begin
                            if (r_gnt[1]) begin
                                r_b_rdata <= bus.VMERdData;
                            end else begin
                                r_a_rdata <= bus.VMERdData;
                            end
                        end
                    end else begin
                        r_state <= StWait;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                    r_gnt   <= 2'b00;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.VMEAddr   = r_vme_addr;
    assign bus.VMEWrData = r_vme_wdata;
    assign bus.VMERdMem  = r_vme_rd;
    assign bus.VMEWrMem  = r_vme_wr;
    assign bus.a_RdData  = r_a_rdata;
    assign bus.b_RdData  = r_b_rdata;
    assign bus.a_RdDone  = r_a_rd_done;
    assign bus.a_WrDone  = r_a_wr_done;
    assign bus.a_RdError = r_a_rd_err;
    assign bus.a_WrError = r_a_wr_err;
    assign bus.b_RdDone  = r_b_rd_done;
    assign bus.b_WrDone  = r_b_wr_done;
    assign bus.b_RdError = r_b_rd_err;
    assign bus.b_WrError = r_b_wr_err;

endmodule

// File: tb/tb_vme_bus_arb.sv
// Directed bench for vme_bus_arb: latency, round-robin, op matching, error priority, timeout, reset.
// Instantiates the DUT with TIMEOUT_CYCLES=4; honours VME_BUS_ARB_TIMEOUT_EN when defined.
module tb_vme_bus_arb;

    logic Clk;
    logic rst_n;

    vme_bus_arb_if bus ();

    vme_bus_arb #(
        .TIMEOUT_CYCLES(4)
    ) u_dut (
        .Clk  (Clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        slv_auto;
    logic [31:0] slv_rdata;
    logic        slv_rd_done, slv_wr_done;
    logic        man_rd_done, man_wr_done, man_rd_err, man_wr_err;
    logic        st_rd, st_wr;

    assign bus.VMERdData  = slv_rdata;
    assign bus.VMERdDone  = slv_rd_done | man_rd_done;
    assign bus.VMEWrDone  = slv_wr_done | man_wr_done;
    assign bus.VMERdError = man_rd_err;
    assign bus.VMEWrError = man_wr_err;

    // Single-cycle slave: answers the strobe seen at one edge during the following cycle.
    initial begin
        slv_rd_done = 1'b0;
        slv_wr_done = 1'b0;
        forever begin
            @(negedge Clk);
            st_rd = bus.VMERdMem;
            st_wr = bus.VMEWrMem;
            @(posedge Clk);
            #1;
            slv_rd_done = st_rd & slv_auto;
            slv_wr_done = st_wr & slv_auto;
        end
    end

    int unsigned cnt_vme_wr  = 0;
    int unsigned cnt_a_rd_dn = 0;
    int unsigned cnt_a_wr_dn = 0;
    int unsigned cnt_b_wr_dn = 0;

    always @(posedge Clk) begin
        cnt_vme_wr  <= cnt_vme_wr  + 32'(bus.VMEWrMem);
        cnt_a_rd_dn <= cnt_a_rd_dn + 32'(bus.a_RdDone);
        cnt_a_wr_dn <= cnt_a_wr_dn + 32'(bus.a_WrDone);
        cnt_b_wr_dn <= cnt_b_wr_dn + 32'(bus.b_WrDone);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    int unsigned snap_wr, snap_awd, snap_bwd, snap_ard;

    initial begin
        rst_n = 1'b0;
        slv_auto = 1'b1;
        slv_rdata = 32'h0;
        man_rd_done = 1'b0;
        man_wr_done = 1'b0;
        man_rd_err = 1'b0;
        man_wr_err = 1'b0;
        bus.a_Addr = '0;
        bus.b_Addr = '0;
        bus.a_WrData = '0;
        bus.b_WrData = '0;
        bus.a_RdMem = 1'b0;
        bus.a_WrMem = 1'b0;
        bus.b_RdMem = 1'b0;
        bus.b_WrMem = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_vmeaddr", 32'(bus.VMEAddr), 32'h0);
        check("rst_vmewrdata", bus.VMEWrData, 32'h0);
        check("rst_a_rddata", bus.a_RdData, 32'h0);
        check("rst_b_rddata", bus.b_RdData, 32'h0);
        check("rst_strobes_pulses",
              32'({bus.VMERdMem, bus.VMEWrMem, bus.a_RdDone, bus.a_WrDone, bus.a_RdError,
                   bus.a_WrError, bus.b_RdDone, bus.b_WrDone, bus.b_RdError, bus.b_WrError}),
              32'h0);
        rst_n = 1'b1;

        // Single read by A, single-cycle slave: done visible three edges after the request edge
        slv_rdata = 32'h0000_00A5;
        bus.a_Addr = 18'h00001;
        bus.a_RdMem = 1'b1;
        tick();
        check("rd_issue_gnt", 32'(bus.gnt), 32'h1);
        check("rd_issue_strobe", 32'(bus.VMERdMem), 32'h1);
        check("rd_issue_addr", 32'(bus.VMEAddr), 32'h1);
        tick();
        check("rd_wait_strobe", 32'(bus.VMERdMem), 32'h0);
        check("rd_wait_gnt", 32'(bus.gnt), 32'h1);
        tick();
        check("rd_resp_done", 32'(bus.a_RdDone), 32'h1);
        check("rd_resp_data", bus.a_RdData, 32'h0000_00A5);
        check("rd_resp_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.a_RdMem = 1'b0;
        check("rd_done_one_cycle", 32'(bus.a_RdDone), 32'h0);
        check("rd_idle_gnt", 32'(bus.gnt), 32'h0);
        check("rd_data_held", bus.a_RdData, 32'h0000_00A5);
        tick();

        // Simultaneous writes after reset: A first, then B
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        snap_wr = cnt_vme_wr;
        snap_awd = cnt_a_wr_dn;
        snap_bwd = cnt_b_wr_dn;
        bus.a_Addr = 18'h00010;
        bus.a_WrData = 32'h1111_1111;
        bus.a_WrMem = 1'b1;
        bus.b_Addr = 18'h00020;
        bus.b_WrData = 32'h2222_2222;
        bus.b_WrMem = 1'b1;
        tick();
        check("wr2_first_gnt", 32'(bus.gnt), 32'h1);
        check("wr2_first_strobe", 32'(bus.VMEWrMem), 32'h1);
        check("wr2_first_addr", 32'(bus.VMEAddr), 32'h10);
        check("wr2_first_data", bus.VMEWrData, 32'h1111_1111);
        tick();
        tick();
        check("wr2_a_done", 32'(bus.a_WrDone), 32'h1);
        check("wr2_b_not_yet", 32'(bus.b_WrDone), 32'h0);
        tick();
        bus.a_WrMem = 1'b0;
        check("wr2_addr_stable", 32'(bus.VMEAddr), 32'h10);
        tick();
        check("wr2_second_gnt", 32'(bus.gnt), 32'h2);
        check("wr2_second_addr", 32'(bus.VMEAddr), 32'h20);
        check("wr2_second_data", bus.VMEWrData, 32'h2222_2222);
        tick();
        tick();
        check("wr2_b_done", 32'(bus.b_WrDone), 32'h1);
        tick();
        bus.b_WrMem = 1'b0;
        tick();
        tick();
        check("wr2_strobe_count", cnt_vme_wr - snap_wr, 32'd2);
        check("wr2_a_done_count", cnt_a_wr_dn - snap_awd, 32'd1);
        check("wr2_b_done_count", cnt_b_wr_dn - snap_bwd, 32'd1);

        // Round-robin with B held: grants go A, B, A, B, A
        bus.a_Addr = 18'h00002;
        bus.b_Addr = 18'h00003;
        slv_rdata = 32'hBEEF_0001;
        bus.a_RdMem = 1'b1;
        bus.b_RdMem = 1'b1;
        tick();
        check("rr_gnt0", 32'(bus.gnt), 32'h1);
        tick();
        tick();
        check("rr_a_done0", 32'(bus.a_RdDone), 32'h1);
        tick();
        bus.a_RdMem = 1'b0;
        tick();
        check("rr_gnt1", 32'(bus.gnt), 32'h2);
        bus.a_RdMem = 1'b1;
        tick();
        tick();
        check("rr_b_done1", 32'(bus.b_RdDone), 32'h1);
        check("rr_b_data1", bus.b_RdData, 32'hBEEF_0001);
        slv_rdata = 32'hCAFE_0002;
        tick();
        tick();
        check("rr_gnt2", 32'(bus.gnt), 32'h1);
        tick();
        tick();
        check("rr_a_data2", bus.a_RdData, 32'hCAFE_0002);
        tick();
        tick();
        check("rr_gnt3", 32'(bus.gnt), 32'h2);
        tick();
        tick();
        check("rr_b_done3", 32'(bus.b_RdDone), 32'h1);
        tick();
        bus.b_RdMem = 1'b0;
        tick();
        check("rr_gnt4", 32'(bus.gnt), 32'h1);
        tick();
        tick();
        check("rr_a_done4", 32'(bus.a_RdDone), 32'h1);
        tick();
        bus.a_RdMem = 1'b0;
        tick();
        check("rr_idle", 32'(bus.gnt), 32'h0);

        // RdMem and WrMem together is a write
        bus.a_Addr = 18'h00004;
        bus.a_WrData = 32'h3333_3333;
        bus.a_RdMem = 1'b1;
        bus.a_WrMem = 1'b1;
        tick();
        check("rw_is_wr_strobe", 32'({bus.VMERdMem, bus.VMEWrMem}), 32'h1);
        check("rw_is_wr_data", bus.VMEWrData, 32'h3333_3333);
        tick();
        tick();
        check("rw_is_wr_resp", 32'({bus.a_RdDone, bus.a_WrDone}), 32'h1);
        tick();
        bus.a_RdMem = 1'b0;
        bus.a_WrMem = 1'b0;
        tick();

        // Non-matching response ignored; Done with Error reports Error only
        slv_auto = 1'b0;
        bus.a_Addr = 18'h00005;
        bus.a_RdMem = 1'b1;
        tick();
        check("mix_gnt", 32'(bus.gnt), 32'h1);
        man_wr_done = 1'b1;
        man_wr_err = 1'b1;
        tick();
        tick();
        man_wr_done = 1'b0;
        man_wr_err = 1'b0;
        check("mix_wr_rsp_ignored",
              32'({bus.gnt, bus.a_RdDone, bus.a_RdError, bus.a_WrDone, bus.a_WrError}), 32'h10);
        man_rd_done = 1'b1;
        man_rd_err = 1'b1;
        tick();
        man_rd_done = 1'b0;
        man_rd_err = 1'b0;
        check("mix_err_wins", 32'({bus.a_RdDone, bus.a_RdError}), 32'h1);
        tick();
        bus.a_RdMem = 1'b0;
        check("mix_err_one_cycle", 32'(bus.a_RdError), 32'h0);
        snap_ard = cnt_a_rd_dn;
        man_rd_done = 1'b1;
        tick();
        tick();
        man_rd_done = 1'b0;
        tick();
        check("idle_rsp_ignored", 32'(bus.gnt), 32'h0);
        check("idle_rsp_no_done", cnt_a_rd_dn - snap_ard, 32'd0);

        // Silent slave
        bus.a_Addr = 18'h00006;
        bus.a_RdMem = 1'b1;
        tick();
`ifdef VME_BUS_ARB_TIMEOUT_EN
        tick();
        tick();
        tick();
        tick();
        check("tmo_not_yet", 32'(bus.a_RdError), 32'h0);
        tick();
        check("tmo_error", 32'({bus.a_RdDone, bus.a_RdError}), 32'h1);
        tick();
        bus.a_RdMem = 1'b0;
        check("tmo_err_one_cycle", 32'(bus.a_RdError), 32'h0);
        check("tmo_idle", 32'(bus.gnt), 32'h0);
        tick();
`else
        for (int i = 0; i < 20; i++) tick();
        check("no_tmo_gnt_held", 32'(bus.gnt), 32'h1);
        check("no_tmo_no_resp", 32'({bus.a_RdDone, bus.a_RdError}), 32'h0);
        rst_n = 1'b0;
        bus.a_RdMem = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        // Reset during WAIT aborts; late slave response is ignored
        snap_ard = cnt_a_rd_dn;
        bus.a_Addr = 18'h00007;
        bus.a_RdMem = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_gnt", 32'(bus.gnt), 32'h0);
        check("abort_addr", 32'(bus.VMEAddr), 32'h0);
        bus.a_RdMem = 1'b0;
        tick();
        rst_n = 1'b1;
        man_rd_done = 1'b1;
        tick();
        tick();
        man_rd_done = 1'b0;
        tick();
        check("abort_no_done", cnt_a_rd_dn - snap_ard, 32'd0);
        check("abort_idle", 32'(bus.gnt), 32'h0);

        slv_auto = 1'b1;
        bus.a_Addr = 18'h00008;
        bus.a_WrData = 32'h4444_4444;
        bus.a_WrMem = 1'b1;
        tick();
        check("post_abort_gnt", 32'(bus.gnt), 32'h1);
        check("post_abort_strobe", 32'(bus.VMEWrMem), 32'h1);
        tick();
        tick();
        check("post_abort_done", 32'(bus.a_WrDone), 32'h1);
        tick();
        bus.a_WrMem = 1'b0;
        tick();
        check("post_abort_idle", 32'(bus.gnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
